// File: rtl/alarm_controller_if.sv
// Signal bundle between the time-compare/button front end and the alarm sequencer.
// master drives the comparator, tick and button inputs; slave is the sequencer itself.
interface alarm_controller_if;
    logic       sec_tick;
    logic       hr_eq;
    logic       min_eq;
    logic       alarm_en;
    logic       snooze_btn;
    logic       stop_btn;
    logic       buzzer;
    logic       ringing;
    logic       snoozing;
    logic [1:0] snooze_count;
    logic       missed;

    modport master (
        output sec_tick, hr_eq, min_eq, alarm_en, snooze_btn, stop_btn,
        input  buzzer, ringing, snoozing, snooze_count, missed
    );

    modport slave (
        input  sec_tick, hr_eq, min_eq, alarm_en, snooze_btn, stop_btn,
        output buzzer, ringing, snoozing, snooze_count, missed
    );
endinterface

// File: rtl/alarm_controller.sv
// Alarm sequencer: fires on the rising edge of hour&minute match, rings with a
// timeout, and allows a bounded number of timed snoozes per alarm event.
module alarm_controller #(
    parameter int RING_SECS   = 60,
    parameter int SNOOZE_SECS = 300,
    parameter int MAX_SNOOZES = 3
) (
    input  logic               clk,
    input  logic               reset,
    alarm_controller_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RINGING, SNOOZE} state_t;

    localparam logic [8:0] RING_LAST = 9'(RING_SECS - 1);
    localparam logic [8:0] SNZ_INIT  = 9'(SNOOZE_SECS);
    localparam logic [1:0] SNZ_MAX   = 2'(MAX_SNOOZES);

    state_t     r_state;
    logic [8:0] r_ring_cnt;
    logic [8:0] r_snz_cnt;
    logic       r_match_d;
    logic       r_primed;
    logic       r_snz_d;
    logic       r_stop_d;
    logic       r_buzzer;
    logic       r_ringing;
    logic       r_snoozing;
    logic       r_missed;
    logic [1:0] r_snooze_count;

    logic w_match;
    logic w_trigger;
    logic w_snz_edge;
    logic w_stop_edge;

    // A match already in progress when reset releases must not fire: the
    // match has to be seen low once before a rising edge is trusted.
    assign w_match     = bus.hr_eq & bus.min_eq;
    assign w_trigger   = w_match & ~r_match_d & bus.alarm_en & r_primed;
    assign w_snz_edge  = bus.snooze_btn & ~r_snz_d;
    assign w_stop_edge = bus.stop_btn & ~r_stop_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= IDLE;
            r_ring_cnt     <= '0;
            r_snz_cnt      <= '0;
            r_match_d      <= 1'b0;
            r_primed       <= 1'b0;
            r_snz_d        <= 1'b0;
            r_stop_d       <= 1'b0;
            r_buzzer       <= 1'b0;
            r_ringing      <= 1'b0;
            r_snoozing     <= 1'b0;
            r_missed       <= 1'b0;
            r_snooze_count <= '0;
        end else begin
            r_match_d <= w_match;
            r_snz_d   <= bus.snooze_btn;
            r_stop_d  <= bus.stop_btn;
            r_missed  <= 1'b0;
            if (!w_match) r_primed <= 1'b1;

            if (!bus.alarm_en || (r_state != IDLE && w_stop_edge)) begin
                r_state        <= IDLE;
                r_buzzer       <= 1'b0;
                r_ringing      <= 1'b0;
                r_snoozing     <= 1'b0;
                r_snooze_count <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_ring_cnt     <= '0;
                        r_snooze_count <= '0;
                        if (w_trigger) begin
                            r_state   <= RINGING;
                            r_buzzer  <= 1'b1;
                            r_ringing <= 1'b1;
                        end
                    end
                    RINGING: begin
                        // A snooze press at the limit falls through so the ring timeout still runs.
                        if (w_snz_edge && r_snooze_count < SNZ_MAX) begin
                            r_state        <= SNOOZE;
                            r_buzzer       <= 1'b0;
                            r_ringing      <= 1'b0;
                            r_snoozing     <= 1'b1;
                            r_snooze_count <= r_snooze_count + 2'd1;
                            r_snz_cnt      <= SNZ_INIT;
                        end else if (bus.sec_tick) begin
                            if (r_ring_cnt == RING_LAST) begin
                                r_state        <= IDLE;
                                r_buzzer       <= 1'b0;
                                r_ringing      <= 1'b0;
                                r_missed       <= 1'b1;
                                r_snooze_count <= '0;
                            end else begin
                                r_ring_cnt <= r_ring_cnt + 9'd1;
                            end
                        end
                    end
                    SNOOZE: begin
                        if (bus.sec_tick) begin
                            if (r_snz_cnt <= 9'd1) begin
                                r_state    <= RINGING;
                                r_buzzer   <= 1'b1;
                                r_ringing  <= 1'b1;
                                r_snoozing <= 1'b0;
                                r_ring_cnt <= '0;
                            end else begin
                                r_snz_cnt <= r_snz_cnt - 9'd1;
                            end
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign bus.buzzer       = r_buzzer;
    assign bus.ringing      = r_ringing;
    assign bus.snoozing     = r_snoozing;
    assign bus.snooze_count = r_snooze_count;
    assign bus.missed       = r_missed;
endmodule
